// File: rtl/calc_entry.sv
// Keypad-driven calculator entry: builds two decimal operands and an operator, hands them to the ALU
// over valid/ready and routes the result to the display. Optional macro: CALC_CHAIN_EN.
module calc_entry #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14,
  parameter int RWIDTH = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pressed,
  input  logic              released,
  input  logic [3:0]        digits,
  input  logic [3:0]        opers,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_op,
  input  logic              res_valid,
  input  logic [RWIDTH-1:0] res_value,
  input  logic              res_neg,
  input  logic              res_err,
  output logic [RWIDTH-1:0] disp_value,
  output logic              disp_neg,
  output logic              disp_err,
  output logic              busy,
  output logic              key_strobe
);
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {S_ENTER_A, S_ENTER_B, S_REQ, S_WAIT, S_SHOW, S_ERR} state_t;

  state_t              r_state, w_state_n;
  logic                r_pressed_q, r_armed, r_key_strobe;
  logic [WIDTH-1:0]    r_a, r_b, w_a_n, w_b_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic [1:0]          r_op, w_op_n;
  logic [RWIDTH-1:0]   r_disp, w_disp_n;
  logic                r_neg, r_err, w_neg_n, w_err_n, w_zero;

  logic                w_busy, w_acc, w_dig, w_op, w_clr, w_eq, w_dig_ok, w_lead0;
  logic [WIDTH-1:0]    w_cur, w_x_new;
  logic [WIDTH+3:0]    w_mac;
  logic [CW-1:0]       w_cnt_new;
  logic [1:0]          w_opc;

  assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT);
  // Rising edge of the held level, once per release; keys during a transaction are dropped.
  assign w_acc  = pressed & ~r_pressed_q & r_armed & ~w_busy;
  assign w_dig  = w_acc && (opers == 4'd0);
  assign w_op   = w_acc && (opers >= 4'd1) && (opers <= 4'd4);
  assign w_clr  = w_acc && (opers == 4'd5);
  assign w_eq   = w_acc && (opers == 4'd6);
  assign w_opc  = 2'(opers - 4'd1);

  assign w_cur     = (r_state == S_ENTER_B) ? r_b : r_a;
  assign w_mac     = {4'd0, w_cur} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, digits};
  assign w_dig_ok  = r_cnt < CW'(DIGITS);
  assign w_lead0   = (r_cnt == '0) && (digits == 4'd0);
  assign w_x_new   = w_lead0 ? w_cur : w_mac[WIDTH-1:0];
  assign w_cnt_new = w_lead0 ? r_cnt : r_cnt + CW'(1);

`ifdef CALC_CHAIN_EN
  localparam logic [RWIDTH-1:0] LIMIT = RWIDTH'(10**DIGITS);
`endif

  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_cnt_n   = r_cnt;
    w_op_n    = r_op;
    w_disp_n  = r_disp;
    w_neg_n   = r_neg;
    w_err_n   = r_err;
    w_zero    = 1'b0;
    case (r_state)
      S_ENTER_A: begin
        if (w_dig && w_dig_ok) begin
          w_a_n    = w_x_new;
          w_cnt_n  = w_cnt_new;
          w_disp_n = RWIDTH'(w_x_new);
        end else if (w_op) begin
          w_op_n    = w_opc;
          w_b_n     = '0;
          w_cnt_n   = '0;
          w_state_n = S_ENTER_B;
        end else if (w_clr) begin
          w_zero = 1'b1;
        end
      end
      S_ENTER_B: begin
        if (w_dig && w_dig_ok) begin
          w_b_n    = w_x_new;
          w_cnt_n  = w_cnt_new;
          w_disp_n = RWIDTH'(w_x_new);
        end else if (w_op) begin
          w_op_n = w_opc;
        end else if (w_eq) begin
          w_state_n = S_REQ;
        end else if (w_clr) begin
          w_zero = 1'b1;
        end
      end
      S_REQ:  if (alu_ready) w_state_n = S_WAIT;
      S_WAIT: begin
        if (res_valid) begin
          if (res_err) begin
            w_disp_n  = '0;
            w_neg_n   = 1'b0;
            w_err_n   = 1'b1;
            w_state_n = S_ERR;
          end else begin
            w_disp_n  = res_value;
            w_neg_n   = res_neg;
            w_state_n = S_SHOW;
          end
        end
      end
      S_SHOW: begin
        if (w_dig) begin
          w_a_n     = WIDTH'(digits);
          w_cnt_n   = CW'(digits != 4'd0);
          w_disp_n  = RWIDTH'(digits);
          w_neg_n   = 1'b0;
          w_state_n = S_ENTER_A;
        end else if (w_clr) begin
          w_zero = 1'b1;
        end
`ifdef CALC_CHAIN_EN
        else if (w_op) begin
          // Result becomes operand A only if it fits an operand; otherwise it is an overflow.
          if (!r_neg && (r_disp < LIMIT)) begin
            w_a_n     = r_disp[WIDTH-1:0];
            w_op_n    = w_opc;
            w_b_n     = '0;
            w_cnt_n   = '0;
            w_state_n = S_ENTER_B;
          end else begin
            w_disp_n  = '0;
            w_neg_n   = 1'b0;
            w_err_n   = 1'b1;
            w_state_n = S_ERR;
          end
        end
`endif
      end
      S_ERR:   if (w_clr) w_zero = 1'b1;
      default: w_state_n = S_ENTER_A;
    endcase
    if (w_zero) begin
      w_a_n     = '0;
      w_b_n     = '0;
      w_cnt_n   = '0;
      w_op_n    = '0;
      w_disp_n  = '0;
      w_neg_n   = 1'b0;
      w_err_n   = 1'b0;
      w_state_n = S_ENTER_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ENTER_A;
      r_pressed_q  <= 1'b0;
      r_armed      <= 1'b1;
      r_key_strobe <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_disp       <= '0;
      r_neg        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pressed_q  <= pressed;
      r_key_strobe <= w_acc;
      if (w_acc)         r_armed <= released;
      else if (released) r_armed <= 1'b1;
      r_a    <= w_a_n;
      r_b    <= w_b_n;
      r_cnt  <= w_cnt_n;
      r_op   <= w_op_n;
      r_disp <= w_disp_n;
      r_neg  <= w_neg_n;
      r_err  <= w_err_n;
    end
  end

  assign alu_valid  = (r_state == S_REQ);
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign busy       = w_busy;
  assign disp_value = r_disp;
  assign disp_neg   = r_neg;
  assign disp_err   = r_err;
  assign key_strobe = r_key_strobe;
endmodule
